mem_port_responder: RTL and testbench

MEM_PORT_RESPONDER -- requirements
Module: mem_port_responder

---
 rtl/mem_port_pkg.sv | 19 +
 rtl/mem_port_responder_if.sv | 25 ++
 rtl/mem_port_responder.sv | 129 ++++++++++++
 tb/tb_mem_port_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared request/response types for the core <-> memory-port link.
package mem_port_pkg;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } opcode_e;

  typedef logic [15:0] data_t;

  typedef struct packed {
    logic       vld;
    opcode_e    opcode;
    logic [15:0] addr;
    data_t      data;
    logic [7:0] access_id;
  } request_t;

endpackage

// File: rtl/mem_port_responder_if.sv
// Core request/response and SRAM port bundle; slave side is the responder.
interface mem_port_responder_if #(
  parameter int SRAM_AW = 10
);
  import mem_port_pkg::*;

  request_t             mem_req;
  logic                 mem_req_grant;
  request_t             mem_rsp;
  logic                 sram_en;
  logic                 sram_we;
  logic [SRAM_AW-1:0]   sram_addr;
  data_t                sram_wdata;
  data_t                sram_rdata;

  modport slave (
    input  mem_req, sram_rdata,
    output mem_req_grant, mem_rsp, sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output mem_req, sram_rdata,
    input  mem_req_grant, mem_rsp, sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/mem_port_responder.sv
// Queued single-port SRAM responder: requests are buffered in a FIFO and
// serviced one at a time in arrival order (IDLE -> ACCESS -> RESP).
module mem_port_responder
  import mem_port_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SRAM_LAT   = 2,
  parameter int SRAM_AW    = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_responder_if.slave  bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  request_t           fifo_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  state_e             state_q, state_d;
  logic [LW-1:0]      lat_q, lat_d;
  request_t           held_q, held_d;
  request_t           rsp_q, rsp_d;
  logic               sram_en_q, sram_en_d, sram_we_q, sram_we_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  data_t              sram_wdata_q, sram_wdata_d;

  logic grant, push, pop;

  // Grant comes only from the registered count, so a same-cycle pop never frees a slot early.
  assign grant = (cnt_q < CW'(FIFO_DEPTH));
  assign push  = bus.mem_req.vld && grant;
  assign pop   = (state_q == IDLE) && (cnt_q != '0);

  // Queue pointer/count bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // Queue storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.mem_req;
  end

  // Next-state and next-output decode; SRAM strobe is launched on the IDLE pop
  // so it is registered and valid in exactly the first ACCESS cycle.
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    held_d       = held_q;
    rsp_d        = '0;
    sram_en_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_addr_d  = '0;
    sram_wdata_d = '0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          held_d       = fifo_q[rd_ptr_q];
          state_d      = ACCESS;
          lat_d        = LW'(SRAM_LAT - 1);
          sram_en_d    = 1'b1;
          sram_we_d    = (fifo_q[rd_ptr_q].opcode == OP_WRITE);
          sram_addr_d  = fifo_q[rd_ptr_q].addr[SRAM_AW-1:0];
          sram_wdata_d = fifo_q[rd_ptr_q].data;
        end
      end
      ACCESS: begin
        if (lat_q == '0) begin
          state_d   = RESP;
          rsp_d     = held_q;
          rsp_d.vld = 1'b1;
          if (held_q.opcode == OP_READ) rsp_d.data = bus.sram_rdata;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All control state and registered outputs; reset drops any queued or in-flight work.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      lat_q        <= '0;
      held_q       <= '0;
      rsp_q        <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      lat_q        <= lat_d;
      held_q       <= held_d;
      rsp_q        <= rsp_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign bus.mem_req_grant = grant;
  assign bus.mem_rsp       = rsp_q;
  assign bus.sram_en       = sram_en_q;
  assign bus.sram_we       = sram_we_q;
  assign bus.sram_addr     = sram_addr_q;
  assign bus.sram_wdata    = sram_wdata_q;

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed bench for mem_port_responder with a behavioural 2-cycle SRAM.
module tb_mem_port_responder;
  import mem_port_pkg::*;

  localparam int SRAM_AW = 10;
  localparam int SRAM_LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  mem_port_responder_if #(.SRAM_AW(SRAM_AW)) mif ();

  mem_port_responder #(.FIFO_DEPTH(4), .SRAM_LAT(SRAM_LAT), .SRAM_AW(SRAM_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: read data appears the cycle after the strobe, i.e. on the last ACCESS cycle.
  data_t mem [1 << SRAM_AW];
  data_t rdata_r = '0;
  assign mif.sram_rdata = rdata_r;
  always @(posedge clk) begin
    if (mif.sram_en) begin
      if (mif.sram_we) mem[mif.sram_addr] <= mif.sram_wdata;
      else             rdata_r <= mem[mif.sram_addr];
    end
  end

  // Monitor on the falling edge: log responses and SRAM strobes, flag idle-value violations.
  request_t            rsp_log [$];
  int                  rsp_cyc [$];
  int                  en_cnt = 0;
  int                  viol = 0;
  logic                last_we = 1'b0;
  logic [SRAM_AW-1:0]  last_addr = '0;
  data_t               last_wdata = '0;
  logic                prev_en = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (mif.sram_en) begin
        en_cnt++;
        last_we = mif.sram_we;
        last_addr = mif.sram_addr;
        last_wdata = mif.sram_wdata;
        if (prev_en) viol++;
      end else if (mif.sram_we || mif.sram_addr != '0 || mif.sram_wdata != '0) begin
        viol++;
      end
      if (mif.mem_rsp.vld) begin
        rsp_log.push_back(mif.mem_rsp);
        rsp_cyc.push_back(cyc);
      end else if (mif.mem_rsp != '0) begin
        viol++;
      end
    end
    prev_en = mif.sram_en;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rsp_log.delete();
    rsp_cyc.delete();
    en_cnt = 0;
  endtask

  int acc_cyc;
  // Present one request for one cycle (queue assumed to have room); records the accept cycle.
  task automatic send(input opcode_e op, input logic [15:0] a, input data_t d, input logic [7:0] id);
    mif.mem_req = '{vld: 1'b1, opcode: op, addr: a, data: d, access_id: id};
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    mif.mem_req = '0;
  endtask

  task automatic wait_rsp(input int n, input string tag);
    for (int i = 0; i < 80 && rsp_log.size() < n; i++) @(posedge clk);
    #1;
    check({tag, "_arrived"}, 64'(rsp_log.size() >= n), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  logic [7:0] gexp;
  logic [7:0] qids [6];

  initial begin
    mif.mem_req = '0;
    #2 reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_grant", 64'(mif.mem_req_grant), 64'd1);
    check("rst_sram_en", 64'(mif.sram_en), 64'd0);
    check("rst_rsp", 64'(mif.mem_rsp), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single write then read-back of the same word
    clear_logs();
    send(OP_WRITE, 16'h0010, 16'hA5A5, 8'h05);
    wait_rsp(1, "wr");
    check("wr_id", 64'(rsp_log[0].access_id), 64'h05);
    check("wr_op", 64'(rsp_log[0].opcode), 64'(OP_WRITE));
    check("wr_data", 64'(rsp_log[0].data), 64'hA5A5);
    check("wr_latency", 64'(rsp_cyc[0] - acc_cyc), 64'(SRAM_LAT + 2));
    check("wr_en_pulses", 64'(en_cnt), 64'd1);
    check("wr_we", 64'(last_we), 64'd1);
    check("wr_addr", 64'(last_addr), 64'h010);
    check("wr_wdata", 64'(last_wdata), 64'hA5A5);
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    send(OP_READ, 16'h0010, 16'h0000, 8'h45);
    wait_rsp(1, "rd");
    check("rd_data", 64'(rsp_log[0].data), 64'hA5A5);
    check("rd_id", 64'(rsp_log[0].access_id), 64'h45);
    check("rd_op", 64'(rsp_log[0].opcode), 64'(OP_READ));
    check("rd_latency", 64'(rsp_cyc[0] - acc_cyc), 64'(SRAM_LAT + 2));
    check("rd_we", 64'(last_we), 64'd0);

    // Address truncation to SRAM_AW bits, echo of full address
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    send(OP_WRITE, 16'h07FF, 16'h1234, 8'h09);
    wait_rsp(1, "trunc");
    check("trunc_sram_addr", 64'(last_addr), 64'h3FF);
    check("trunc_rsp_addr", 64'(rsp_log[0].addr), 64'h07FF);
    check("trunc_rsp_data", 64'(rsp_log[0].data), 64'h1234);

    // Back-to-back ids 1,2,3
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      mif.mem_req = '{vld: 1'b1, opcode: OP_READ, addr: 16'h0010, data: 16'h0, access_id: 8'(k + 1)};
      @(posedge clk);
      #1;
    end
    mif.mem_req = '0;
    wait_rsp(3, "b2b");
    check("b2b_id0", 64'(rsp_log[0].access_id), 64'd1);
    check("b2b_id1", 64'(rsp_log[1].access_id), 64'd2);
    check("b2b_id2", 64'(rsp_log[2].access_id), 64'd3);
    check("b2b_gap01", 64'(rsp_cyc[1] - rsp_cyc[0]), 64'(SRAM_LAT + 2));
    check("b2b_gap12", 64'(rsp_cyc[2] - rsp_cyc[1]), 64'(SRAM_LAT + 2));

    // Queue full: vld held 8 cycles from reset; grant per cycle 1,1,1,1,1,0,1,0
    do_reset();
    clear_logs();
    gexp = 8'b0101_1111;
    for (int k = 0; k < 8; k++) begin
      mif.mem_req = '{vld: 1'b1, opcode: OP_READ, addr: 16'h0020, data: 16'h0, access_id: 8'(k + 1)};
      @(negedge clk);
      check($sformatf("qfull_grant%0d", k), 64'(mif.mem_req_grant), 64'(gexp[k]));
      @(posedge clk);
      #1;
    end
    mif.mem_req = '0;
    qids = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7};
    wait_rsp(6, "qfull");
    repeat (8) @(posedge clk);
    #1;
    check("qfull_count", 64'(rsp_log.size()), 64'd6);
    for (int k = 0; k < 6; k++)
      check($sformatf("qfull_id%0d", k), 64'(rsp_log[k].access_id), 64'(qids[k]));

    // Reset during ACCESS with two entries still queued
    for (int k = 0; k < 3; k++) begin
      mif.mem_req = '{vld: 1'b1, opcode: OP_READ, addr: 16'h0010, data: 16'h0, access_id: 8'(8'h21 + k)};
      @(posedge clk);
      #1;
    end
    mif.mem_req = '0;
    reset = 1'b0;
    #1;
    clear_logs();
    check("midrst_sram_en", 64'(mif.sram_en), 64'd0);
    check("midrst_rsp", 64'(mif.mem_rsp), 64'd0);
    check("midrst_grant", 64'(mif.mem_req_grant), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("postrst_grant", 64'(mif.mem_req_grant), 64'd1);
    repeat (12) @(posedge clk);
    #1;
    check("postrst_no_rsp", 64'(rsp_log.size()), 64'd0);
    check("postrst_no_en", 64'(en_cnt), 64'd0);
    send(OP_READ, 16'h0010, 16'h0000, 8'h66);
    wait_rsp(1, "postrst_rd");
    check("postrst_rd_data", 64'(rsp_log[0].data), 64'hA5A5);
    check("postrst_rd_id", 64'(rsp_log[0].access_id), 64'h66);

    // Invalid request: fields set, vld low, for 10 cycles
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    mif.mem_req = '{vld: 1'b0, opcode: OP_WRITE, addr: 16'h0123, data: 16'hBEEF, access_id: 8'h77};
    repeat (10) @(posedge clk);
    #1;
    mif.mem_req = '0;
    repeat (6) @(posedge clk);
    #1;
    check("inv_no_en", 64'(en_cnt), 64'd0);
    check("inv_no_rsp", 64'(rsp_log.size()), 64'd0);
    check("inv_grant", 64'(mif.mem_req_grant), 64'd1);

    check("idle_value_violations", 64'(viol), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
